// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter sitting on the core's data bus.
// Byte stores to TX_ADDR are queued in a FIFO and sent 8N1 (LSB first) on tx.
// Reads of STAT_ADDR return a combinational status word; writing bit2 of
// STAT_ADDR clears the sticky overflow flag.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (frame grows to 11 bit times).
//
// Ports:
//   clk         system clock, rising-edge
//   reset       synchronous active-high reset
//   MemWrite    store strobe from core
//   DataAdr     byte address from core
//   WriteData   store data from core
//   StatusData  status word when DataAdr == STAT_ADDR, else 0 (combinational)
//                 [0] empty [1] full [2] overflow [3] busy [7:4] count (sat 15)
//   tx          serial line, idle high
//   busy        high while a frame is on the line
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
    parameter logic [31:0] STAT_ADDR    = 32'h0000_0104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] StatusData,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W-1:0]  DEPTH_P   = PTR_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   count;
    logic               empty;
    logic               full;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               clr_req;
    logic               overflow;
    logic [3:0]         count_sat;
    logic [7:0]         shreg;
    logic [2:0]         bit_idx;
    logic [BAUD_W-1:0]  baud;
`ifdef UART_TX_PARITY_EN
    logic               par_bit;
`endif

    // FIFO occupancy from wrap-around pointers with an extra MSB
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign full     = (count == DEPTH_P);

    // Bus decode; a push into a full FIFO still succeeds if a pop frees a slot
    assign push_req = MemWrite && (DataAdr == TX_ADDR);
    assign clr_req  = MemWrite && (DataAdr == STAT_ADDR) && WriteData[2];
    assign pop      = (state == S_IDLE) && !empty;
    assign push     = push_req && (!full || pop);

    assign count_sat  = (32'(count) > 32'd15) ? 4'hF : 4'(count);
    assign StatusData = (DataAdr == STAT_ADDR)
                      ? {24'h0, count_sat, busy, overflow, full, empty}
                      : 32'h0;

    // FIFO storage (contents need no reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= WriteData[7:0];
        end
    end

    // FIFO pointers and sticky overflow (set wins over clear)
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_req && !push) begin
                overflow <= 1'b1;
            end else if (clr_req) begin
                overflow <= 1'b0;
            end
        end
    end

    // Transmit FSM; tx and busy are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    baud <= '0;
                    if (!empty) begin
                        shreg   <= mem[rd_ptr[ADDR_W-1:0]];
`ifdef UART_TX_PARITY_EN
                        par_bit <= ^mem[rd_ptr[ADDR_W-1:0]];
`endif
                        state   <= S_START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud == BAUD_LAST) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        tx      <= shreg[0];
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            tx    <= par_bit;
`else
                            state <= S_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            // shreg[1] is the next bit once this shift lands
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        state <= S_STOP;
                        tx    <= 1'b1;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        state <= S_IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    baud  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
module tb_mmio_uart_tx;

    localparam int          CPB       = 4;
    localparam int          DEPTH     = 8;
    localparam logic [31:0] TX_ADDR   = 32'h0000_0100;
    localparam logic [31:0] STAT_ADDR = 32'h0000_0104;
`ifdef UART_TX_PARITY_EN
    localparam int          FRAME_BITS = 11;
`else
    localparam int          FRAME_BITS = 10;
`endif
    localparam int          FRAME_CYC = FRAME_BITS * CPB;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] StatusData;
    logic        tx;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic       cap_en = 1'b0;
    logic       capq[$];
    logic [7:0] dec_q[$];
    int         dec_start[$];

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .TX_ADDR     (TX_ADDR),
        .STAT_ADDR   (STAT_ADDR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .StatusData(StatusData),
        .tx        (tx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line recorder: one tx sample per cycle, taken mid-cycle
    always @(negedge clk) begin
        if (cap_en) capq.push_back(tx);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Ideal line level at cycle c after a store in cycle 0 into an idle UART
    function automatic logic model_tx(input int c, input logic [7:0] d, input logic par);
        int s;
        if (c < 2 || c >= 2 + FRAME_CYC) return 1'b1;
        s = (c - 2) / CPB;
        if (s == 0) return 1'b0;
        if (s <= 8) return d[s-1];
        if (FRAME_BITS == 11 && s == 9) return par;
        return 1'b1;
    endfunction

    // Decode recorded samples into frames by mid-bit sampling
    task automatic decode();
        int i;
        int n;
        logic [7:0] b;
        dec_q.delete();
        dec_start.delete();
        n = capq.size();
        i = 0;
        while (i + FRAME_CYC <= n) begin
            if (capq[i] == 1'b0) begin
                check($sformatf("start_bit@%0d", i), 32'(capq[i + CPB/2]), 32'd0);
                for (int j = 0; j < 8; j++) b[j] = capq[i + CPB*(1+j) + CPB/2];
                if (FRAME_BITS == 11)
                    check($sformatf("parity@%0d", i), 32'(capq[i + CPB*9 + CPB/2]), 32'(^b));
                check($sformatf("stop_bit@%0d", i),
                      32'(capq[i + CPB*(FRAME_BITS-1) + CPB/2]), 32'd1);
                dec_q.push_back(b);
                dec_start.push_back(i);
                i += FRAME_CYC;
            end else begin
                i++;
            end
        end
    endtask

    // One-cycle store; entered and left at #1 after a rising edge
    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        MemWrite  = 1'b1;
        DataAdr   = addr;
        WriteData = data;
        @(posedge clk); #1;
        MemWrite  = 1'b0;
        DataAdr   = STAT_ADDR;
        WriteData = 32'h0;
    endtask

    typedef struct packed {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] exp_q[$];
    int         lows;

    initial begin
        vecs[0] = '{data: 8'hA5, par: 1'b0};
        vecs[1] = '{data: 8'h07, par: 1'b1};
        vecs[2] = '{data: 8'h00, par: 1'b0};
        vecs[3] = '{data: 8'hFF, par: 1'b0};
        vecs[4] = '{data: 8'h80, par: 1'b1};

        reset = 1'b1; MemWrite = 1'b0; DataAdr = STAT_ADDR; WriteData = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_status", StatusData, 32'h1);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Single-byte frames: cycle-exact line, busy and status
        foreach (vecs[e]) begin
            MemWrite  = 1'b1;
            DataAdr   = TX_ADDR;
            WriteData = (32'($urandom) & 32'hFFFF_FF00) | 32'(vecs[e].data);
            for (int c = 0; c <= FRAME_CYC + 2; c++) begin
                @(negedge clk);
                check($sformatf("v%0d_tx_c%0d", e, c), 32'(tx),
                      32'(model_tx(c, vecs[e].data, vecs[e].par)));
                check($sformatf("v%0d_busy_c%0d", e, c), 32'(busy),
                      32'((c >= 2 && c < 2 + FRAME_CYC) ? 1 : 0));
                if (c == 0) check($sformatf("v%0d_stat_c0", e), StatusData, 32'h0);
                if (c == 1) check($sformatf("v%0d_stat_c1", e), StatusData, 32'h10);
                if (c == 2) check($sformatf("v%0d_stat_c2", e), StatusData, 32'h9);
                @(posedge clk); #1;
                if (c == 0) begin
                    MemWrite = 1'b0;
                    DataAdr  = STAT_ADDR;
                end
            end
        end

        // Overflow: ten back-to-back stores into an 8-deep FIFO
        capq.delete();
        cap_en = 1'b1;
        for (int k = 0; k < 10; k++) store(TX_ADDR, 32'(k));
        MemWrite = 1'b1; DataAdr = STAT_ADDR; WriteData = 32'h4;
        @(negedge clk);
        check("ovf_status", StatusData, 32'h8E);
        @(posedge clk); #1;
        MemWrite = 1'b0; WriteData = 32'h0;
        @(negedge clk);
        check("ovf_cleared", StatusData, 32'h8A);
        repeat (9 * (FRAME_CYC + 1) + 20) @(posedge clk);
        #1 cap_en = 1'b0;
        decode();
        check("ovf_nframes", 32'(dec_q.size()), 32'd9);
        for (int k = 0; k < 9 && k < dec_q.size(); k++) begin
            check($sformatf("ovf_byte%0d", k), 32'(dec_q[k]), 32'(k));
            if (k == 0) check("ovf_first_start", 32'(dec_start[0]), 32'd2);
            else check($sformatf("ovf_gap%0d", k), 32'(dec_start[k] - dec_start[k-1]),
                       32'(FRAME_CYC + 1));
        end
        @(negedge clk);
        check("ovf_drained", StatusData, 32'h1);
        @(posedge clk); #1;

        // Randomized bursts against a queue-of-bytes model
        for (int r = 0; r < 4; r++) begin
            int nb;
            logic [7:0] b;
            exp_q.delete();
            capq.delete();
            cap_en = 1'b1;
            nb = $urandom_range(1, DEPTH);
            for (int k = 0; k < nb; k++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                store(TX_ADDR, (32'($urandom) & 32'hFFFF_FF00) | 32'(b));
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #0;
            end
            repeat (DEPTH * (FRAME_CYC + 1) + 20) @(posedge clk);
            #1 cap_en = 1'b0;
            decode();
            check($sformatf("rnd%0d_nframes", r), 32'(dec_q.size()), 32'(exp_q.size()));
            for (int k = 0; k < exp_q.size() && k < dec_q.size(); k++)
                check($sformatf("rnd%0d_byte%0d", r, k), 32'(dec_q[k]), 32'(exp_q[k]));
            @(negedge clk);
            check($sformatf("rnd%0d_status", r), StatusData, 32'h1);
            @(posedge clk); #1;
        end

        // Reset mid-frame with bytes still queued
        for (int k = 0; k < 3; k++) store(TX_ADDR, 32'(8'h3C + k));
        repeat (17) @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_in_frame", 32'(busy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_status", StatusData, 32'h1);
        lows = 0;
        repeat (150) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("midrst_quiet", 32'(lows), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
